// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

  localparam int unsigned DefaultWidth = 6;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = x - y - bin, with borrow-out.
module full_subtractor_cell (
  input  logic x_i,
  input  logic y_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = x_i ^ y_i ^ bin_i;
  assign bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock through a single borrow flop.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic bit_d, bit_bout;

  full_subtractor_cell u_cell (
    .x_i   (sa_q[0]),
    .y_i   (sb_q[0]),
    .bin_i (br_q),
    .d_o   (bit_d),
    .bout_o(bit_bout)
  );

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    diff_d   = diff_q;
    br_d     = br_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start_i) begin
          state_d = StRun;
          sa_d    = a_i;
          sb_d    = b_i;
          br_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      StRun: begin
        res_d = {bit_d, res_q[WIDTH-1:1]};
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        br_d  = bit_bout;
        cnt_d = cnt_q + 1'b1;
        // Publish only on the last bit so diff/borrow hold through the next run.
        if (cnt_q == CntLast) begin
          state_d  = StDone;
          diff_d   = {bit_d, res_q[WIDTH-1:1]};
          borrow_d = bit_bout;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy_o   = (state_q == StRun);
  assign done_o   = (state_q == StDone);
  assign diff_o   = diff_q;
  assign borrow_o = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=6.
module tb_serial_subtractor;

  localparam int unsigned W = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow;
  logic [W-1:0] diff;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (busy),
    .done_o  (done),
    .diff_o  (diff),
    .borrow_o(borrow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Present operands with start for one edge, then scramble them to prove they were captured.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~av;
    b     = ~bv;
  endtask

  // Count edges after acceptance until done; optionally pulse start (with junk operands) mid-run.
  task automatic wait_done(input int pulse_at, output int cyc, output int gaps, output int chg);
    logic [W-1:0] d0;
    d0   = diff;
    cyc  = -1;
    gaps = 0;
    chg  = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      start = (i == pulse_at);
      if (i == pulse_at) begin
        a = 6'd1;
        b = 6'd2;
      end
      if (done) begin
        cyc = i;
        break;
      end
      if (!busy) gaps++;
      if (diff !== d0) chg++;
    end
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb, input int pulse_at,
                        input bit idle_after);
    int cyc, gaps, chg;
    launch(av, bv);
    chk({tag, ".busy_start"}, busy, 1);
    chk({tag, ".done_start"}, done, 0);
    wait_done(pulse_at, cyc, gaps, chg);
    chk({tag, ".latency"}, cyc, W);
    chk({tag, ".busy_gaps"}, gaps, 0);
    chk({tag, ".diff_held"}, chg, 0);
    chk({tag, ".busy_at_done"}, busy, 0);
    chk({tag, ".diff"}, diff, ed);
    chk({tag, ".borrow"}, borrow, eb);
    if (idle_after) begin
      @(posedge clk);
      #1;
      chk({tag, ".done_pulse"}, done, 0);
      chk({tag, ".idle_busy"}, busy, 0);
      chk({tag, ".diff_idle"}, diff, ed);
    end
  endtask

  initial begin
    int cyc, gaps, chg;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.diff", diff, 0);
    chk("rst.borrow", borrow, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("v40_24", 6'd40, 6'd24, 6'd16, 1'b0, 0, 1'b1);
    run_op("v16_40", 6'd16, 6'd40, 6'd40, 1'b1, 0, 1'b1);
    run_op("v0_1",   6'd0,  6'd1,  6'd63, 1'b1, 0, 1'b1);
    run_op("v63_0",  6'd63, 6'd0,  6'd63, 1'b0, 0, 1'b1);
    run_op("v40_40", 6'd40, 6'd40, 6'd0,  1'b0, 0, 1'b1);
    run_op("v1_63",  6'd1,  6'd63, 6'd2,  1'b1, 0, 1'b1);
    run_op("ignore", 6'd50, 6'd7,  6'd43, 1'b0, 3, 1'b1);

    // Back-to-back: start asserted during the DONE cycle.
    run_op("b2b1", 6'd40, 6'd24, 6'd16, 1'b0, 0, 1'b0);
    launch(6'd5, 6'd9);
    chk("b2b.busy_resume", busy, 1);
    chk("b2b.done_drop", done, 0);
    chk("b2b.diff_held", diff, 16);
    wait_done(0, cyc, gaps, chg);
    chk("b2b2.latency", cyc, W);
    chk("b2b2.busy_gaps", gaps, 0);
    chk("b2b2.diff_held", chg, 0);
    chk("b2b2.diff", diff, 60);
    chk("b2b2.borrow", borrow, 1);
    @(posedge clk);
    #1;
    chk("b2b2.idle", busy, 0);

    // Reset mid-run discards the partial result and clears outputs.
    launch(6'd50, 6'd7);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    chk("mid.busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid.busy", busy, 0);
    chk("mid.done", done, 0);
    chk("mid.diff", diff, 0);
    chk("mid.borrow", borrow, 0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid.idle_busy", busy, 0);
    chk("mid.idle_done", done, 0);
    run_op("v10_3", 6'd10, 6'd3, 6'd7, 1'b0, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
